speck_crypt_iter: RTL and testbench

SPECK_CRYPT_ITER -- requirements
Module: speck_crypt_iter

---
 rtl/speck_pkg.sv | 30 +++
 rtl/speck_round_unit.sv | 37 +++
 rtl/speck_crypt_iter.sv | 155 +++++++++++++++
 tb/tb_speck_crypt_iter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_pkg.sv
// Shared definitions for the Speck block cipher core: controller states,
// parameter legality checks and the per-width default rotate amounts.
package speck_pkg;

    typedef enum logic [2:0] {
        NOKEY  = 3'd0,
        EXPAND = 3'd1,
        IDLE   = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic bit legal_w(input int unsigned w);
        return (w == 16) || (w == 24) || (w == 32) || (w == 48) || (w == 64);
    endfunction

    function automatic bit legal_key_words(input int unsigned m);
        return (m >= 2) && (m <= 4);
    endfunction

    // Speck32 is the only family member with smaller rotate amounts.
    function automatic int unsigned default_alpha(input int unsigned w);
        return (w == 16) ? 7 : 8;
    endfunction

    function automatic int unsigned default_beta(input int unsigned w);
        return (w == 16) ? 2 : 3;
    endfunction

endpackage

// File: rtl/speck_round_unit.sv
// One combinational Speck round; INVERSE selects the encrypt round (0)
// or the decrypt (inverse) round (1).
module speck_round_unit #(
    parameter int unsigned W       = 32,
    parameter int unsigned ALPHA   = 8,
    parameter int unsigned BETA    = 3,
    parameter bit          INVERSE = 1'b0
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] k,
    output logic [W-1:0] x_next,
    output logic [W-1:0] y_next
);

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int unsigned s);
        return (v << s) | (v >> (W - s));
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int unsigned s);
        return (v >> s) | (v << (W - s));
    endfunction

    if (INVERSE) begin : g_inv
        // The subtraction uses the already-recovered y of this round.
        always_comb begin
            y_next = ror(y ^ x, BETA);
            x_next = rol((x ^ k) - y_next, ALPHA);
        end
    end else begin : g_fwd
        always_comb begin
            x_next = (ror(x, ALPHA) + y) ^ k;
            y_next = rol(y, BETA) ^ x_next;
        end
    end

endmodule

// File: rtl/speck_crypt_iter.sv
// Iterative Speck cipher: one key-schedule step or one round per cycle.
// Define SPECK_DEC_EN to build the decrypt datapath (mode_in = 1).
module speck_crypt_iter
    import speck_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned ROUNDS    = 27,
    parameter int unsigned ALPHA     = default_alpha(W),
    parameter int unsigned BETA      = default_beta(W)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_WORDS*W-1:0] key_in,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [W-1:0]           x_in,
    input  logic [W-1:0]           y_in,
    input  logic                   mode_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           x_out,
    output logic [W-1:0]           y_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned LW = KEY_WORDS - 1;
    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    if (!legal_w(W) || !legal_key_words(KEY_WORDS) || (ROUNDS == 0)) begin : g_bad_cfg
        $error("speck_crypt_iter: illegal W, KEY_WORDS or ROUNDS");
    end

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int unsigned s);
        return (v << s) | (v >> (W - s));
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int unsigned s);
        return (v >> s) | (v << (W - s));
    endfunction

    state_t        state;
    logic [RW-1:0] rnd;
    logic [W-1:0]  k_reg;
    logic [W-1:0]  l_reg [LW];
    logic [W-1:0]  rk    [ROUNDS];
    logic [W-1:0]  x_reg, y_reg;
    logic [W-1:0]  l_new, k_new;
    logic [W-1:0]  enc_x, enc_y, x_rnd, y_rnd;

    assign key_ready = (state == NOKEY) || (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign x_out     = x_reg;
    assign y_out     = y_reg;

    // Key schedule: the l words form a FIFO, oldest in l_reg[0].
    always_comb begin
        l_new = (k_reg + ror(l_reg[0], ALPHA)) ^ W'(rnd);
        k_new = rol(k_reg, BETA) ^ l_new;
    end

    speck_round_unit #(.W(W), .ALPHA(ALPHA), .BETA(BETA), .INVERSE(1'b0)) u_enc (
        .x(x_reg), .y(y_reg), .k(rk[rnd]), .x_next(enc_x), .y_next(enc_y)
    );

`ifdef SPECK_DEC_EN
    logic         mode_reg;
    logic [W-1:0] dec_x, dec_y;

    speck_round_unit #(.W(W), .ALPHA(ALPHA), .BETA(BETA), .INVERSE(1'b1)) u_dec (
        .x(x_reg), .y(y_reg), .k(rk[LAST - rnd]), .x_next(dec_x), .y_next(dec_y)
    );

    always_comb begin
        x_rnd = mode_reg ? dec_x : enc_x;
        y_rnd = mode_reg ? dec_y : enc_y;
    end
`else
    logic unused_mode;
    assign unused_mode = mode_in;

    always_comb begin
        x_rnd = enc_x;
        y_rnd = enc_y;
    end
`endif

    always_ff @(posedge clk) begin
        if (state == EXPAND) rk[rnd] <= k_reg;
    end

    // A key offered together with a block in IDLE wins; the block is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NOKEY;
            rnd   <= '0;
            k_reg <= '0;
            x_reg <= '0;
            y_reg <= '0;
            for (int unsigned j = 0; j < LW; j++) l_reg[j] <= '0;
`ifdef SPECK_DEC_EN
            mode_reg <= 1'b0;
`endif
        end else if (key_ready && key_valid) begin
            state <= EXPAND;
            rnd   <= '0;
            k_reg <= key_in[W-1:0];
            for (int unsigned j = 0; j < LW; j++) l_reg[j] <= key_in[(j+1)*W +: W];
        end else begin
            case (state)
                EXPAND: begin
                    k_reg <= k_new;
                    for (int unsigned j = 0; j + 1 < LW; j++) l_reg[j] <= l_reg[j+1];
                    l_reg[LW-1] <= l_new;
                    if (rnd == LAST) begin
                        state <= IDLE;
                        rnd   <= '0;
                    end else begin
                        rnd <= rnd + 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        rnd   <= '0;
                        x_reg <= x_in;
                        y_reg <= y_in;
`ifdef SPECK_DEC_EN
                        mode_reg <= mode_in;
`endif
                    end
                end
                RUN: begin
                    x_reg <= x_rnd;
                    y_reg <= y_rnd;
                    if (rnd == LAST) begin
                        state <= DONE;
                        rnd   <= '0;
                    end else begin
                        rnd <= rnd + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                NOKEY: ;
                default: state <= NOKEY;
            endcase
        end
    end

endmodule

// File: tb/tb_speck_crypt_iter.sv
// Self-checking bench for speck_crypt_iter (Speck64/128 and Speck32/64 instances).
module tb_speck_crypt_iter;

    localparam int unsigned T32 = 27;
    localparam int unsigned T16 = 22;
`ifdef SPECK_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [127:0] key_in;
    logic         key_valid, key_ready, mode_in, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]  x_in, y_in, x_out, y_out;

    logic [63:0]  h_key_in;
    logic         h_key_valid, h_key_ready, h_mode_in, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0]  h_x_in, h_y_in, h_x_out, h_y_out;

    int checks   = 0;
    int failures = 0;
    logic [127:0] cur_key;

    speck_crypt_iter #(.W(32), .KEY_WORDS(4), .ROUNDS(T32), .ALPHA(8), .BETA(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .x_in(x_in), .y_in(y_in), .mode_in(mode_in), .in_valid(in_valid), .in_ready(in_ready),
        .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    speck_crypt_iter #(.W(16), .KEY_WORDS(4), .ROUNDS(T16), .ALPHA(7), .BETA(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .key_in(h_key_in), .key_valid(h_key_valid), .key_ready(h_key_ready),
        .x_in(h_x_in), .y_in(h_y_in), .mode_in(h_mode_in), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .x_out(h_x_out), .y_out(h_y_out), .out_valid(h_out_valid), .out_ready(h_out_ready)
    );

    // ---------------- reference model (plain Speck arithmetic) ----------------
    function automatic logic [63:0] wmask(input int unsigned w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rot_r(input logic [63:0] v, input int unsigned s, input int unsigned w);
        logic [63:0] m = wmask(w);
        v = v & m;
        return ((v >> s) | (v << (w - s))) & m;
    endfunction

    function automatic logic [63:0] rot_l(input logic [63:0] v, input int unsigned s, input int unsigned w);
        logic [63:0] m = wmask(w);
        v = v & m;
        return ((v << s) | (v >> (w - s))) & m;
    endfunction

    function automatic logic [127:0] model(input logic [255:0] key, input logic [63:0] xi, input logic [63:0] yi,
                                           input bit dec, input int unsigned w, input int unsigned m,
                                           input int unsigned t, input int unsigned a, input int unsigned b);
        logic [63:0] msk, k, x, y;
        logic [63:0] l  [80];
        logic [63:0] rk [40];
        msk = wmask(w);
        k = 64'(key) & msk;
        for (int unsigned j = 0; j < m - 1; j++) l[j] = 64'(key >> ((j + 1) * w)) & msk;
        rk[0] = k;
        for (int unsigned i = 0; i + 1 < t; i++) begin
            l[i+m-1] = ((k + rot_r(l[i], a, w)) ^ 64'(i)) & msk;
            k        = rot_l(k, b, w) ^ l[i+m-1];
            rk[i+1]  = k;
        end
        x = xi & msk;
        y = yi & msk;
        if (!dec) begin
            for (int unsigned i = 0; i < t; i++) begin
                x = ((rot_r(x, a, w) + y) & msk) ^ rk[i];
                y = rot_l(y, b, w) ^ x;
            end
        end else begin
            for (int unsigned i = t; i > 0; i--) begin
                y = rot_r(y ^ x, b, w);
                x = rot_l(((x ^ rk[i-1]) - y) & msk, a, w);
            end
        end
        return {x, y};
    endfunction

    // ---------------- stimulus helpers for the 32-bit instance ----------------
    task automatic load_key(input logic [127:0] k, input string name);
        int n = 0;
        key_in    = k;
        key_valid = 1'b1;
        while (!key_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_key_ready: got %0b, required 1", name, key_ready);
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        cur_key   = k;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != int'(T32)) begin
            failures++;
            $display("FAIL %s_expand_cycles: got %0d, required %0d", name, n, T32);
        end
    endtask

    // Returns in DONE when out_ready is low, otherwise back in IDLE.
    task automatic send_block(input logic [31:0] x, input logic [31:0] y, input logic mode,
                              output logic [31:0] xo, output logic [31:0] yo, input string name);
        int n = 0;
        x_in = x; y_in = y; mode_in = mode; in_valid = 1'b1;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != int'(T32)) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges after transfer, required %0d", name, n, T32);
        end
        xo = x_out;
        yo = y_out;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({key_ready, in_ready, out_valid, x_out, y_out} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            failures++;
            $display("FAIL reset32: kr/ir/ov=%0b%0b%0b x=%h y=%h, required 100 x=0 y=0",
                     key_ready, in_ready, out_valid, x_out, y_out);
        end
        checks++;
        if ({h_key_ready, h_in_ready, h_out_valid, h_x_out, h_y_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset16: kr/ir/ov=%0b%0b%0b x=%h y=%h, required 100 x=0 y=0",
                     h_key_ready, h_in_ready, h_out_valid, h_x_out, h_y_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_kat();
        logic [31:0]  xo, yo;
        logic [127:0] exp;
        load_key(128'h1b1a1918_13121110_0b0a0908_03020100, "kat");
        send_block(32'h3b726574, 32'h7475432d, 1'b0, xo, yo, "kat_enc");
        checks++;
        if ({xo, yo} !== 64'h8c6fa548_454e028b) begin
            failures++;
            $display("FAIL kat_enc: got %h %h, required 8c6fa548 454e028b", xo, yo);
        end
        // With decrypt built this recovers the plaintext; without, it encrypts.
        exp = model({128'h0, cur_key}, 64'h8c6fa548, 64'h454e028b, DEC_EN, 32, 4, T32, 8, 3);
        send_block(32'h8c6fa548, 32'h454e028b, 1'b1, xo, yo, "kat_dec");
        checks++;
        if ({xo, yo} !== {exp[95:64], exp[31:0]}) begin
            failures++;
            $display("FAIL kat_mode1: got %h %h, required %h %h", xo, yo, exp[95:64], exp[31:0]);
        end
        exp = model({128'h0, cur_key}, 64'h3b726574, 64'h7475432d, DEC_EN, 32, 4, T32, 8, 3);
        send_block(32'h3b726574, 32'h7475432d, 1'b1, xo, yo, "kat_mode1_pt");
        checks++;
        if ({xo, yo} !== {exp[95:64], exp[31:0]}) begin
            failures++;
            $display("FAIL kat_mode1_pt: got %h %h, required %h %h", xo, yo, exp[95:64], exp[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0]  xo, yo, x, y;
        logic         md;
        logic [127:0] exp;
        for (int kk = 0; kk < 3; kk++) begin
            load_key({$urandom, $urandom, $urandom, $urandom}, "rnd");
            for (int bb = 0; bb < 4; bb++) begin
                x = $urandom; y = $urandom; md = 1'($urandom_range(0, 1));
                exp = model({128'h0, cur_key}, {32'h0, x}, {32'h0, y}, md & DEC_EN, 32, 4, T32, 8, 3);
                send_block(x, y, md, xo, yo, "rnd");
                checks++;
                if ({xo, yo} !== {exp[95:64], exp[31:0]}) begin
                    failures++;
                    $display("FAIL rnd_block k%0d b%0d mode%0b: got %h %h, required %h %h",
                             kk, bb, md, xo, yo, exp[95:64], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  xo, yo, xh, yh, x, y;
        logic [127:0] exp;
        x = $urandom; y = $urandom;
        exp = model({128'h0, cur_key}, {32'h0, x}, {32'h0, y}, 1'b0, 32, 4, T32, 8, 3);
        out_ready = 1'b0;
        send_block(x, y, 1'b0, xh, yh, "bp");
        checks++;
        if ({xh, yh} !== {exp[95:64], exp[31:0]}) begin
            failures++;
            $display("FAIL bp_result: got %h %h, required %h %h", xh, yh, exp[95:64], exp[31:0]);
        end
        // A competing key and block are offered while the result is held.
        key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1;
        x_in = $urandom; y_in = $urandom; mode_in = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, key_ready, x_out, y_out} !== {1'b1, 1'b0, 1'b0, xh, yh}) begin
                failures++;
                $display("FAIL bp_hold c%0d: ov/ir/kr=%0b%0b%0b x=%h y=%h, required 100 x=%h y=%h",
                         c, out_valid, in_ready, key_ready, x_out, y_out, xh, yh);
            end
        end
        key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: ov/ir=%0b%0b, required 01", out_valid, in_ready);
        end
        x = $urandom; y = $urandom;
        exp = model({128'h0, cur_key}, {32'h0, x}, {32'h0, y}, 1'b0, 32, 4, T32, 8, 3);
        send_block(x, y, 1'b0, xo, yo, "bp_after");
        checks++;
        if ({xo, yo} !== {exp[95:64], exp[31:0]}) begin
            failures++;
            $display("FAIL bp_old_key: got %h %h, required %h %h", xo, yo, exp[95:64], exp[31:0]);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        int stalled_bad = 0;
        x_in = 32'h3b726574; y_in = 32'h7475432d; mode_in = 1'b0; in_valid = 1'b1;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin @(posedge clk); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_ready, in_ready, out_valid, x_out, y_out} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            failures++;
            $display("FAIL midrun_reset: kr/ir/ov=%0b%0b%0b x=%h y=%h, required 100 x=0 y=0",
                     key_ready, in_ready, out_valid, x_out, y_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // in_valid stays high through NOKEY and EXPAND and must be stalled.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0) stalled_bad++;
        end
        key_in = 128'h1b1a1918_13121110_0b0a0908_03020100; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != int'(T32) || stalled_bad != 0) begin
            failures++;
            $display("FAIL midrun_stall: in_ready after %0d edges (required %0d), early in_ready %0d (required 0)",
                     n, T32, stalled_bad);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != int'(T32) || {x_out, y_out} !== 64'h8c6fa548_454e028b) begin
            failures++;
            $display("FAIL midrun_result: %0d edges x=%h y=%h, required %0d edges 8c6fa548 454e028b",
                     n, x_out, y_out, T32);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_w16();
        int n;
        logic [15:0]  x, y;
        logic [127:0] exp;
        h_key_in = 64'h1918_1110_0908_0100; h_key_valid = 1'b1;
        n = 0;
        while (!h_key_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        h_key_valid = 1'b0;
        n = 0;
        while (!h_in_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != int'(T16)) begin
            failures++;
            $display("FAIL w16_expand_cycles: got %0d, required %0d", n, T16);
        end
        for (int bb = 0; bb < 4; bb++) begin
            x = (bb == 0) ? 16'h6574 : 16'($urandom);
            y = (bb == 0) ? 16'h694c : 16'($urandom);
            exp = model({192'h0, h_key_in}, {48'h0, x}, {48'h0, y}, 1'b0, 16, 4, T16, 7, 2);
            h_x_in = x; h_y_in = y; h_mode_in = 1'b0; h_in_valid = 1'b1;
            n = 0;
            while (!h_in_ready && n < 200) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            h_in_valid = 1'b0;
            n = 0;
            while (!h_out_valid && n < 200) begin @(posedge clk); #1; n++; end
            checks++;
            if (n != int'(T16) || {h_x_out, h_y_out} !== {exp[79:64], exp[15:0]}) begin
                failures++;
                $display("FAIL w16_block b%0d: %0d edges x=%h y=%h, required %0d edges %h %h",
                         bb, n, h_x_out, h_y_out, T16, exp[79:64], exp[15:0]);
            end
            if (bb == 0) begin
                checks++;
                if ({h_x_out, h_y_out} !== 32'ha868_42f2) begin
                    failures++;
                    $display("FAIL w16_kat: got %h %h, required a868 42f2", h_x_out, h_y_out);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        key_in = '0; key_valid = 1'b0; x_in = '0; y_in = '0; mode_in = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; cur_key = '0;
        h_key_in = '0; h_key_valid = 1'b0; h_x_in = '0; h_y_in = '0; h_mode_in = 1'b0;
        h_in_valid = 1'b0; h_out_ready = 1'b1;
        test_reset();
        test_kat();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
